// File: rtl/coef_ram_pkg.sv
// Shared definitions for the coefficient store: FSM encoding, default widths, lane helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package coef_ram_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int LANE_W_DEF = 16;
  localparam int LANES_DEF  = 4;
  localparam int TAG_W_DEF  = 10;
  localparam int WORD_W_DEF = LANES_DEF * LANE_W_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Lane k of a default-width coefficient word; lane 0 is the least significant.
  function automatic logic [LANE_W_DEF-1:0] lane_of(input logic [WORD_W_DEF-1:0] word,
                                                    input int unsigned k);
    return word[k*LANE_W_DEF +: LANE_W_DEF];
  endfunction

endpackage

// File: rtl/coef_ram_mem.sv
// Coefficient storage: DEPTH x WORD_W, one synchronous write port, one synchronous read port.
// Latency: read data registered, 1 cycle; a same-edge write is not visible (read-old-data).
// Backpressure: none; both ports accept every cycle.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out (registered).
module coef_ram_mem #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; miss tracking lives in the top level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/coef_ram_buf.sv
// Coefficient buffer for the CORDIC iteration control: load port, clear sweep, tagged reads.
// Latency: read 2 cycles (stage 1 = RAM/forward/written bit, stage 2 = output register).
// Backpressure: ld_ready low during the clear sweep; reads have no backpressure.
// Ports: clk, reset (async active-low); ld_valid/ld_ready/ld_addr/ld_data load port;
//        clr_start pulse, busy; rd_valid/rd_addr/rd_tag read request;
//        out_valid/out_data/out_tag/out_miss registered read result.
module coef_ram_buf
  import coef_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [LANES*LANE_W-1:0] ld_data,
  input  logic                    clr_start,
  output logic                    busy,
  input  logic                    rd_valid,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [TAG_W-1:0]        rd_tag,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_miss
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = LANES * LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [DEPTH-1:0]  written_q;

  // Unified write port: the loader in IDLE, the zeroing sweep in CLEAR.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_bit;

  logic [WORD_W-1:0] mem_rd_data;
  logic              fwd_hit;

  logic              s1_vld;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_fwd;
  logic [WORD_W-1:0] s1_fwd_data;
  logic              s1_wbit;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    ld_ready = 1'b0;
    busy     = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = ld_addr;
    wr_data  = ld_data;
    wr_bit   = 1'b1;
    case (state_q)
      IDLE: begin
        ld_ready = 1'b1;
        wr_en    = ld_valid;
        // A load in the clr_start cycle still lands; the sweep zeroes it later.
        if (clr_start) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = sweep_q;
        wr_data = '0;
        wr_bit  = 1'b0;
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sweep_d = '0;
      end
    endcase
  end

  // ---------------- written bitmap ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written_q <= '0;
    end else if (wr_en) begin
      written_q[wr_addr] <= wr_bit;
    end
  end

  // ---------------- storage ----------------
  coef_ram_mem #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // The RAM returns old data on a same-edge collision, so the colliding write
  // is captured here and substituted in stage 2.
  assign fwd_hit = wr_en && (wr_addr == rd_addr);

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld      <= 1'b0;
      s1_tag      <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
      s1_wbit     <= 1'b0;
    end else begin
      s1_vld      <= rd_valid;
      s1_tag      <= rd_tag;
      s1_fwd      <= fwd_hit;
      s1_fwd_data <= wr_data;
      s1_wbit     <= fwd_hit ? wr_bit : written_q[rd_addr];
    end
  end

  // ---------------- stage 2 (outputs hold when no read completes) ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_miss  <= 1'b0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data <= s1_fwd ? s1_fwd_data : mem_rd_data;
        out_tag  <= s1_tag;
        out_miss <= ~s1_wbit;
      end
    end
  end

endmodule

// File: tb/tb_coef_ram_buf.sv
// Bench for coef_ram_buf: directed scenarios plus randomized traffic against a behavioural model.
// Latency: expects each read result exactly 2 cycles after its request.
// Backpressure: checks ld_ready/busy across the clear sweep.
module tb_coef_ram_buf;
  import coef_ram_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int WW    = 64;
  localparam int TW    = 10;

  logic          clk, reset;
  logic          ld_valid, ld_ready, clr_start, busy, rd_valid;
  logic [AW-1:0] ld_addr, rd_addr;
  logic [WW-1:0] ld_data, out_data;
  logic [TW-1:0] rd_tag, out_tag;
  logic          out_valid, out_miss;

  coef_ram_buf #(.ADDR_W(AW), .LANE_W(16), .LANES(4), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .clr_start(clr_start), .busy(busy),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_miss(out_miss)
  );

  typedef struct {
    int            cyc;
    logic [WW-1:0] data;
    bit            known;
    bit            miss;
    logic [TW-1:0] tag;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  // Behavioural model: array contents, written flags, and a remaining-sweep position.
  logic [WW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_wr    [DEPTH];
  bit            m_busy;
  int            m_sweep;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    rec_t o;
    if (out_valid === 1'b1) begin
      o.cyc = cyc; o.data = out_data; o.known = 1'b1; o.miss = out_miss; o.tag = out_tag;
      obs_q.push_back(o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drives one cycle of inputs and advances the model by the same cycle.
  task automatic drive_cycle(input bit lv, input logic [AW-1:0] la, input logic [WW-1:0] ld,
                             input bit clr, input bit rv, input logic [AW-1:0] ra,
                             input logic [TW-1:0] rt);
    rec_t e;
    ld_valid = lv; ld_addr = la; ld_data = ld; clr_start = clr;
    rd_valid = rv; rd_addr = ra; rd_tag = rt;
    if (!m_busy) begin
      if (lv) begin m_mem[la] = ld; m_known[la] = 1; m_wr[la] = 1; end
      if (clr) begin m_busy = 1; m_sweep = 0; end
    end else begin
      m_mem[m_sweep] = '0; m_known[m_sweep] = 1; m_wr[m_sweep] = 0;
      m_sweep++;
      if (m_sweep == DEPTH) begin m_busy = 0; m_sweep = 0; end
    end
    if (rv) begin
      e.cyc = cyc; e.data = m_mem[ra]; e.known = m_known[ra]; e.miss = !m_wr[ra]; e.tag = rt;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset;
    rec_t e, o;
    ld_valid = 0; ld_addr = '0; ld_data = '0; clr_start = 0; rd_valid = 0; rd_addr = '0; rd_tag = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_miss !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got vld=%b data=%h tag=%h miss=%b busy=%b, want all 0",
               out_valid, out_data, out_tag, out_miss, busy);
    end
    m_busy = 0; m_sweep = 0;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ld_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got ld_ready=%b busy=%b, want 1/0", ld_ready, busy);
    end
    exp_q.delete(); obs_q.delete();
    drive_cycle(0, '0, '0, 0, 1, 6'd17, 10'h011);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL unwritten_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL unwritten_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_load_read;
    rec_t e, o;
    logic [WW-1:0] w;
    w = 64'h0001_0002_0003_0004;
    drive_cycle(1, 6'd5, w, 0, 0, '0, '0);
    idle(1);
    drive_cycle(0, '0, '0, 0, 1, 6'd5, 10'h155);
    drive_cycle(1, 6'd6, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, '0, '0);
    drive_cycle(0, '0, '0, 0, 1, 6'd6, 10'h066);
    drive_cycle(0, '0, '0, 0, 1, 6'd5, 10'h2A5);
    idle(3);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== w || out_tag !== 10'h2A5 || lane_of(out_data, 0) !== 16'h0004) begin
      n_bad++;
      $display("FAIL hold: got vld=%b data=%h tag=%h, want 0/%h/2a5", out_valid, out_data, out_tag, w);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL load_read_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL load_read_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_forward;
    rec_t e, o;
    drive_cycle(1, 6'd9, 64'h1111_1111_1111_1111, 0, 0, '0, '0);
    drive_cycle(1, 6'd9, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1, 6'd9, 10'h001);
    drive_cycle(1, 6'd10, 64'h5555_5555_5555_5555, 0, 1, 6'd9, 10'h002);
    drive_cycle(1, 6'd10, 64'h7777_0000_7777_0000, 0, 1, 6'd10, 10'h003);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL forward_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL forward_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stream;
    rec_t e, o;
    for (int a = 0; a < DEPTH; a++) drive_cycle(1, AW'(a), {$urandom, $urandom}, 0, 0, '0, '0);
    for (int a = 0; a < DEPTH; a++) drive_cycle(0, '0, '0, 0, 1, AW'(a), TW'(a));
    idle(3);
    n_cmp++;
    if (obs_q.size() !== DEPTH || exp_q.size() !== DEPTH) begin
      n_bad++; $display("FAIL stream_count: got %0d results, want %0d", obs_q.size(), DEPTH);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL stream_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear;
    rec_t e, o;
    logic [AW-1:0] ra;
    // Load in the clr_start cycle is accepted, then swept.
    drive_cycle(1, 6'd7, 64'hCAFE_F00D_CAFE_F00D, 1, 0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || ld_ready !== 1'b0) begin
        n_bad++; $display("FAIL sweep_flags[%0d]: got busy=%b ld_ready=%b, want 1/0", i, busy, ld_ready);
      end
      ra = (i % 2 == 0) ? AW'(i) : AW'($urandom_range(DEPTH - 1));
      drive_cycle(1, AW'($urandom_range(DEPTH - 1)), {$urandom, $urandom}, (i == 5), 1, ra, TW'(i + 100));
    end
    n_cmp++;
    if (busy !== 1'b0 || ld_ready !== 1'b1) begin
      n_bad++; $display("FAIL sweep_end: got busy=%b ld_ready=%b, want 0/1", busy, ld_ready);
    end
    drive_cycle(0, '0, '0, 0, 1, 6'd63, 10'h3F0);
    drive_cycle(0, '0, '0, 0, 1, 6'd7, 10'h3F1);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL clear_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL clear_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    logic [AW-1:0] la, ra;
    for (int i = 0; i < 400; i++) begin
      la = AW'($urandom_range(DEPTH - 1));
      ra = ($urandom_range(1) == 1) ? la : AW'($urandom_range(DEPTH - 1));
      drive_cycle($urandom_range(1) == 1, la, {$urandom, $urandom}, $urandom_range(99) == 0,
                  $urandom_range(3) != 0, ra, TW'($urandom));
    end
    while (m_busy) idle(1);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL b2b_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL b2b_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_sweep;
    rec_t e, o;
    drive_cycle(1, 6'd30, 64'h3030_3030_3030_3030, 0, 0, '0, '0);
    drive_cycle(0, '0, '0, 1, 0, '0, '0);
    idle(20);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_miss !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b vld=%b data=%h tag=%h miss=%b, want all 0",
               busy, out_valid, out_data, out_tag, out_miss);
    end
    m_busy = 0; m_sweep = 0;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || ld_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_release: got busy=%b ld_ready=%b, want 0/1", busy, ld_ready);
    end
    drive_cycle(1, 6'd3, 64'h0000_0000_0000_1234, 0, 0, '0, '0);
    drive_cycle(0, '0, '0, 0, 1, 6'd3, 10'h033);
    drive_cycle(0, '0, '0, 0, 1, 6'd30, 10'h030);
    drive_cycle(0, '0, '0, 0, 1, 6'd10, 10'h010);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL abort_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.cyc !== e.cyc + 2 || o.tag !== e.tag || o.miss !== e.miss || (e.known && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL abort_rd: got cyc=%0d tag=%h miss=%b data=%h, want cyc=%0d tag=%h miss=%b data=%h",
                 o.cyc, o.tag, o.miss, o.data, e.cyc + 2, e.tag, e.miss, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_forward();
    test_stream();
    test_clear();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coef_ram_buf.md
# coef_ram_buf

Parametrised coefficient store for the hyperbolic CORDIC datapath. It succeeds the fixed 64×48 table: word width, lane count and depth are generic. A ready/valid load port and a hardware clear sweep are added, plus an explicit read-during-write forwarding rule and a registered two-stage read pipeline. The block sits between the host/loader and the CORDIC iteration control, and delivers per-iteration constant lanes (XM/YM/XR/YR-style) together with a passthrough tag.

## Interface
Parameters:
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
- LANE_W, 16, bits per output lane
- LANES, 4, lanes per word; WORD_W = LANES*LANE_W
- TAG_W, 10, width of the passthrough tag (iteration index)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; asserting (0) resets the state immediately
- ld_valid  in  1  load request
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- ld_addr  in  ADDR_W  load address
- ld_data  in  WORD_W  load word; lane k = bits [k*LANE_W +: LANE_W]
- clr_start  in  1  one-cycle pulse; starts the clear sweep
- busy  out  1  clear sweep in progress
- rd_valid  in  1  read request (no backpressure)
- rd_addr  in  ADDR_W  read address
- rd_tag  in  TAG_W  tag carried alongside the read
- out_valid  out  1  out_* fields valid
- out_data  out  WORD_W  read word
- out_tag  out  TAG_W  rd_tag delayed by 2
- out_miss  out  1  the entry read has not been written since reset or the last clear

## Operation
- States: IDLE, CLEAR.
  - IDLE → CLEAR on clr_start.
  - CLEAR → IDLE after the write to address DEPTH-1.
  - clr_start is ignored while in CLEAR.
- IDLE behaviour:
  - ld_ready = 1.
  - An accepted load writes mem[ld_addr] <= ld_data and sets written[ld_addr].
- CLEAR behaviour:
  - ld_ready = 0 and busy = 1.
  - A sweep counter runs 0..DEPTH-1, one entry per cycle.
  - Each cycle it writes zero and clears written[addr].
  - Sweep length is exactly DEPTH cycles.
- In the clr_start cycle the block is still IDLE, so a simultaneous accepted load is performed. The sweep then overwrites that entry.
- Reads are accepted in every state, every cycle.
- Read-during-write: if a write (load or sweep) targets rd_addr in the same cycle as rd_valid:
  - out_data returns the new (written) data.
  - out_miss returns the new written bit: 0 for a load, 1 for a sweep write.
- A write in a later cycle does not affect a read already issued.
- Reset (asynchronous, active-low):
  - State → IDLE, sweep counter → 0, written bitmap → all 0.
  - out_valid, out_data, out_tag → 0; out_miss → 0; busy → 0; ld_ready → 1 after release.
  - Memory contents are not reset.
- Reset mid-sweep aborts the sweep. Entries already swept stay zero; all entries report miss.

## Timing
- Read latency is 2 cycles: rd_valid in cycle t gives out_valid in t+2.
  - Stage 1 registers the memory word, the forwarded value and the written bit.
  - Stage 2 is the output register.
- Full throughput: one read per cycle, with back-to-back reads to any addresses.
- out_* hold their last values when out_valid = 0. Only out_valid is forced low.
- Load write latency is 1 cycle. A read issued the cycle after the load returns the new data without forwarding.
- busy rises in the cycle after clr_start and falls in the cycle after the DEPTH-1 write. Total duration is DEPTH cycles.
- Address compare for forwarding uses the registered write address and data only within the same edge. No combinational path runs from ld_* to out_*.

## Structure
- Package coef_ram_pkg holds:
  - The state encoding (IDLE=0, CLEAR=1).
  - Default widths.
  - The lane-extract helper (function returning lane k of a word).
- Sub-module coef_ram_mem holds the storage: DEPTH×WORD_W, one synchronous write port, one synchronous read port with read-old-data semantics.
- Forwarding, the written bitmap, the FSM and the pipeline live in the top level.

## Test plan
- Load addr 5 = 0x0001_0002_0003_0004, read addr 5 two cycles later → out_data = that value, out_miss = 0, out_valid exactly 2 cycles after rd_valid, out_tag matches.
- Load addr 9 = 0xAAAA… and read addr 9 in the same cycle → out_data = 0xAAAA… (forwarded). Read addr 9 while loading addr 10 → old addr-9 data.
- Read an unwritten address after reset → out_miss = 1.
- clr_start after filling all 64 entries:
  - busy high for 64 cycles; ld_ready = 0 throughout; ld_valid held high is not accepted.
  - A read of addr 63 after the sweep → data 0, out_miss = 1.
- Streaming reads of addresses 0..63 with tags 0..63 → 64 consecutive out_valid cycles, in order, with correct data and tags.
- Assert reset at sweep cycle 20, then reload addr 3 = 0x1234 → sweep aborted, busy = 0, outputs 0; read 3 → 0x1234, out_miss = 0; read 30 → out_miss = 1.
